// File: rtl/bp_table_ctrl_pkg.sv
// Shared frontend definitions for the branch-predictor table sequencers.
//   bp_ctrl_state_e    : controller FSM states
//   bp_upd_entry_t     : one buffered resolved-branch update {pc, taken}
//   BP_UPD_QUEUE_DEPTH : default depth of the update FIFO
//   BP_VLEN            : PC width carried in a FIFO entry
package bp_table_ctrl_pkg;

  localparam int unsigned BP_UPD_QUEUE_DEPTH = 4;
  localparam int unsigned BP_VLEN            = 64;

  typedef enum logic [1:0] {
    START = 2'd0,
    SWEEP = 2'd1,
    RUN   = 2'd2
  } bp_ctrl_state_e;

  typedef struct packed {
    logic [BP_VLEN-1:0] pc;
    logic               taken;
  } bp_upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO for branch-predictor updates.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : drop all entries (wins over push/pop)
//   push_i/data_i : enqueue one entry (caller guarantees not full, or pop)
//   pop_i         : dequeue head entry (caller guarantees not empty)
//   data_o        : head entry
//   full_o/empty_o: occupancy flags
module bp_upd_fifo
  import bp_table_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = BP_UPD_QUEUE_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  bp_upd_entry_t data_i,
  input  logic          pop_i,
  output bp_upd_entry_t data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  bp_upd_entry_t mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: data_o is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Write sequencer for one branch-predictor counter table.
// Buffers resolved-branch updates and issues them to the table's single
// write port; sweeps every row with the init value after reset and flush.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_bp_i         : predictor flush (pulse or level)
//   debug_mode_i       : ignore new updates (queued ones still drain)
//   upd_valid_i/pc/taken: resolved-branch update from execute
//   wr_valid_o/ready_i : table write handshake
//   wr_init_o, wr_row_o: sweep write and its row
//   wr_pc_o, wr_taken_o: counter update payload
//   pred_en_o          : table contents valid
//   drop_o             : an update was discarded this cycle
//   busy_o             : sweep in progress or updates pending
module bp_table_ctrl
  import bp_table_ctrl_pkg::*;
#(
  parameter int unsigned NR_ROWS     = 256,
  parameter int unsigned ROW_W       = $clog2(NR_ROWS),
  parameter int unsigned VLEN        = 64,
  parameter int unsigned QUEUE_DEPTH = BP_UPD_QUEUE_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_bp_i,
  input  logic             debug_mode_i,
  input  logic             upd_valid_i,
  input  logic [VLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  output logic             wr_valid_o,
  input  logic             wr_ready_i,
  output logic             wr_init_o,
  output logic [ROW_W-1:0] wr_row_o,
  output logic [VLEN-1:0]  wr_pc_o,
  output logic             wr_taken_o,
  output logic             pred_en_o,
  output logic             drop_o,
  output logic             busy_o
);

  bp_ctrl_state_e   state_q, state_d;
  logic [ROW_W-1:0] sweep_cnt_q, sweep_cnt_d;

  logic          fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  bp_upd_entry_t fifo_in, fifo_head;
  logic          upd_live;

  assign fifo_in.pc    = BP_VLEN'(upd_pc_i);
  assign fifo_in.taken = upd_taken_i;

  bp_upd_fifo #(.DEPTH(QUEUE_DEPTH)) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (fifo_clr),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    wr_valid_o  = 1'b0;
    wr_init_o   = 1'b0;
    wr_row_o    = '0;
    wr_pc_o     = '0;
    wr_taken_o  = 1'b0;
    pred_en_o   = 1'b0;
    fifo_clr    = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      START: state_d = SWEEP;
      SWEEP: begin
        wr_valid_o = 1'b1;
        wr_init_o  = 1'b1;
        wr_row_o   = sweep_cnt_q;
        // Flush restarts from row 0 and discards this cycle's handshake.
        if (flush_bp_i) begin
          sweep_cnt_d = '0;
        end else if (wr_ready_i) begin
          if (sweep_cnt_q == ROW_W'(NR_ROWS-1)) begin
            sweep_cnt_d = '0;
            state_d     = RUN;
          end else begin
            sweep_cnt_d = sweep_cnt_q + ROW_W'(1);
          end
        end
      end
      RUN: begin
        pred_en_o  = 1'b1;
        wr_valid_o = !fifo_empty;
        if (!fifo_empty) begin
          wr_pc_o    = VLEN'(fifo_head.pc);
          wr_taken_o = fifo_head.taken;
        end
        if (flush_bp_i) begin
          fifo_clr    = 1'b1;
          sweep_cnt_d = '0;
          state_d     = SWEEP;
        end else begin
          fifo_pop = !fifo_empty && wr_ready_i;
        end
      end
      default: state_d = START;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign upd_live  = upd_valid_i && !debug_mode_i;
  assign fifo_push = upd_live && (state_q == RUN) && !flush_bp_i &&
                     (!fifo_full || fifo_pop);
  assign drop_o    = upd_live && !fifo_push;
  assign busy_o    = (state_q != RUN) || !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= START;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
module tb_bp_table_ctrl;

  localparam int NR_ROWS = 8;
  localparam int ROW_W   = 3;
  localparam int VLEN    = 64;
  localparam int QD      = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_bp_i, debug_mode_i, upd_valid_i, upd_taken_i, wr_ready_i;
  logic [VLEN-1:0]  upd_pc_i;
  logic             wr_valid_o, wr_init_o, wr_taken_o, pred_en_o, drop_o, busy_o;
  logic [ROW_W-1:0] wr_row_o;
  logic [VLEN-1:0]  wr_pc_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_table_ctrl #(.NR_ROWS(NR_ROWS), .ROW_W(ROW_W), .VLEN(VLEN), .QUEUE_DEPTH(QD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_init_o(wr_init_o),
    .wr_row_o(wr_row_o), .wr_pc_o(wr_pc_o), .wr_taken_o(wr_taken_o),
    .pred_en_o(pred_en_o), .drop_o(drop_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = tk;
  endtask

  task automatic no_upd();
    upd_valid_i = 1'b0;
    upd_pc_i    = '0;
    upd_taken_i = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc, input logic tk);
    #1;
    chk({tag, "_vld"}, wr_valid_o, 1);
    chk({tag, "_init"}, wr_init_o, 0);
    chk({tag, "_pc"}, wr_pc_o, pc);
    chk({tag, "_tk"}, wr_taken_o, tk);
  endtask

  task automatic chk_sweep(input int row);
    #1;
    chk("sw_vld", wr_valid_o, 1);
    chk("sw_init", wr_init_o, 1);
    chk("sw_row", wr_row_o, row);
    chk("sw_pc", wr_pc_o, 0);
    chk("sw_pred", pred_en_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0; wr_ready_i = 1'b1;
    no_upd();
    #23;
    // Reset values
    chk("rst_vld", wr_valid_o, 0);
    chk("rst_init", wr_init_o, 0);
    chk("rst_row", wr_row_o, 0);
    chk("rst_pc", wr_pc_o, 0);
    chk("rst_tk", wr_taken_o, 0);
    chk("rst_pred", pred_en_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_busy", busy_o, 1);
    tick();
    rst_ni = 1'b1;
    // Cycle 1 after release: START
    #1 chk("start_vld", wr_valid_o, 0);
    chk("start_pred", pred_en_o, 0);
    for (int r = 0; r < NR_ROWS; r++) begin
      tick();
      chk_sweep(r);
    end
    tick();
    #1 chk("run_pred", pred_en_o, 1);
    chk("run_vld", wr_valid_o, 0);
    chk("run_busy", busy_o, 0);

    // Fill FIFO with ready low, fifth update drops
    wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      upd(64'h100 + 64'(4*i), (i != 1));
      #1 chk("fill_drop", drop_o, 0);
      tick();
    end
    upd(64'h110, 1'b1);
    #1 chk("full_drop", drop_o, 1);
    chk("full_busy", busy_o, 1);
    tick();
    no_upd();
    wr_ready_i = 1'b1;
    chk_head("dr0", 64'h100, 1); tick();
    chk_head("dr1", 64'h104, 0); tick();
    chk_head("dr2", 64'h108, 1); tick();
    chk_head("dr3", 64'h10C, 1); tick();
    #1 chk("dr_empty", wr_valid_o, 0);

    // Full FIFO with simultaneous pop and push
    wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      upd(64'h200 + 64'(4*i), i[0]);
      tick();
    end
    wr_ready_i = 1'b1;
    upd(64'h210, 1'b1);
    #1 chk("pp_drop", drop_o, 0);
    chk_head("pp0", 64'h200, 0);
    tick();
    no_upd();
    chk_head("pp1", 64'h204, 1); tick();
    chk_head("pp2", 64'h208, 0); tick();
    chk_head("pp3", 64'h20C, 1); tick();
    chk_head("pp4", 64'h210, 1); tick();
    #1 chk("pp_empty", wr_valid_o, 0);

    // Flush with 3 entries queued; head discarded though ready is high
    wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      upd(64'h300 + 64'(4*i), 1'b1);
      tick();
    end
    no_upd();
    wr_ready_i = 1'b1;
    flush_bp_i = 1'b1;
    #1 chk("fl_pred", pred_en_o, 1);
    tick();
    flush_bp_i = 1'b0;
    for (int r = 0; r < NR_ROWS; r++) begin
      if (r == 3) upd(64'h500, 1'b1);
      chk_sweep(r);
      if (r == 3) chk("fl_drop", drop_o, 1);
      chk("fl_busy", busy_o, 1);
      tick();
      no_upd();
    end
    #1 chk("fl_pred_back", pred_en_o, 1);
    chk("fl_lost", wr_valid_o, 0);
    chk("fl_busy_end", busy_o, 0);

    // Held-high flush keeps row 0, then flush again at row 5
    flush_bp_i = 1'b1;
    tick();
    chk_sweep(0);
    tick();
    chk_sweep(0);
    flush_bp_i = 1'b0;
    for (int r = 0; r < 5; r++) begin
      chk_sweep(r);
      tick();
    end
    chk_sweep(5);
    flush_bp_i = 1'b1;
    tick();
    flush_bp_i = 1'b0;
    for (int r = 0; r < NR_ROWS; r++) begin
      chk_sweep(r);
      tick();
    end
    #1 chk("f5_pred", pred_en_o, 1);

    // Debug mode: queued entries drain, new update silently ignored
    wr_ready_i = 1'b0;
    upd(64'h400, 1'b1); tick();
    upd(64'h404, 1'b0); tick();
    debug_mode_i = 1'b1;
    wr_ready_i   = 1'b1;
    upd(64'h408, 1'b1);
    #1 chk("dbg_drop", drop_o, 0);
    chk_head("dbg0", 64'h400, 1);
    tick();
    no_upd();
    chk_head("dbg1", 64'h404, 0);
    tick();
    #1 chk("dbg_empty", wr_valid_o, 0);
    chk("dbg_busy", busy_o, 0);
    debug_mode_i = 1'b0;

    // Asynchronous reset mid-drain
    wr_ready_i = 1'b0;
    upd(64'h600, 1'b1); tick();
    no_upd();
    #2 rst_ni = 1'b0;
    #1 chk("arst_vld", wr_valid_o, 0);
    chk("arst_pred", pred_en_o, 0);
    chk("arst_pc", wr_pc_o, 0);
    chk("arst_busy", busy_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
# bp_table_ctrl

Sequencer for one branch-predictor counter table: local BHT, global BHT or the choice (meta) predictor. It buffers resolved-branch updates from execute in a small FIFO and issues them one at a time to the table's single write port. It also performs multi-cycle initialisation sweeps of the table after reset and on a predictor flush, because FPGA RAM cannot be cleared in one cycle. It sits in the frontend between the execute-side update bus and the table RAM, and gates prediction use while a sweep is running.

## Interface
- NR_ROWS, 256: table rows; power of two, at least 2.
- ROW_W, $clog2(NR_ROWS): row index width.
- VLEN, 64: PC width.
- QUEUE_DEPTH, 4: update FIFO entries; power of two, at least 2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_bp_i  in  1  predictor flush request (single-cycle pulse or level).
- debug_mode_i  in  1  core is in debug mode; new updates are ignored.
- upd_valid_i  in  1  resolved-branch update strobe; execute never stalls.
- upd_pc_i  in  VLEN  branch PC.
- upd_taken_i  in  1  resolved direction.
- wr_valid_o  out  1  write request to the table.
- wr_ready_i  in  1  table accepts the write this cycle.
- wr_init_o  out  1  1 = sweep write of the table's init value; 0 = counter update.
- wr_row_o  out  ROW_W  row to write during a sweep; 0 when not sweeping.
- wr_pc_o  out  VLEN  update PC; 0 during a sweep.
- wr_taken_o  out  1  update direction; 0 during a sweep.
- pred_en_o  out  1  table contents are valid; the frontend ignores predictions while this is 0.
- drop_o  out  1  one-cycle pulse: an update was discarded.
- busy_o  out  1  sweep in progress or FIFO not empty.

## Operation
- FSM has three states: START, SWEEP, RUN.
- START: entered on reset and held for exactly one cycle. wr_valid_o=0. Moves to SWEEP.
- SWEEP:
  - wr_valid_o=1, wr_init_o=1, wr_row_o=sweep_cnt.
  - sweep_cnt increments on each wr_valid_o && wr_ready_i handshake.
  - The handshake at row NR_ROWS-1 moves the FSM to RUN; sweep_cnt wraps to 0.
- RUN:
  - wr_valid_o = FIFO not empty; wr_init_o=0; head entry drives wr_pc_o and wr_taken_o.
  - The head entry is popped on handshake.
  - pred_en_o=1 only in RUN.
- Push rule: push when upd_valid_i && !debug_mode_i && state==RUN && !flush_bp_i && (not full || pop this cycle). Full plus simultaneous pop is accepted.
- Drop rule: upd_valid_i && !debug_mode_i, while full without a pop, or state!=RUN, or flush_bp_i, raises drop_o for one cycle.
- Updates with debug_mode_i=1 are ignored silently: no push, no drop_o. Entries already in the FIFO still drain during debug mode.
- flush_bp_i in RUN: the FIFO is cleared (in-flight head discarded even if wr_ready_i is high that cycle), sweep_cnt=0, next state SWEEP.
- flush_bp_i in SWEEP: sweep restarts at row 0 next cycle; the current handshake is ignored.
- flush_bp_i in START: no effect; START still proceeds to SWEEP.
- Held-high flush_bp_i keeps the block in SWEEP at row 0.
- FIFO arithmetic: rd/wr pointers of $clog2(QUEUE_DEPTH)+1 bits, full/empty derived from the MSB comparison, modular wrap.

## Timing
- Reset values: state START, sweep_cnt 0, FIFO empty, wr_valid_o 0, wr_init_o 0, wr_row_o 0, wr_pc_o 0, wr_taken_o 0, pred_en_o 0, drop_o 0, busy_o 1.
- Reset asserted mid-sweep or mid-drain: everything returns to the reset values immediately (asynchronous).
- Sweep length: NR_ROWS cycles with wr_ready_i held high. pred_en_o rises the cycle after the last sweep handshake.
- Push to wr_valid_o: 1 cycle (registered FIFO, no bypass).
- Back-to-back updates with wr_ready_i high drain at 1 per cycle.
- wr_* outputs are combinational from state and FIFO head only; there is no path from wr_ready_i to wr_valid_o.

## Structure
- Shared frontend package holds: bp_ctrl_state_e {START, SWEEP, RUN}; the FIFO entry struct {pc, taken}; the BP_UPD_QUEUE_DEPTH default.
- One sub-module: bp_upd_fifo, a synchronous FIFO with clear, push/pop, full/empty. The controller FSM stays in the top module.

## Test plan
- Reset release, NR_ROWS=8, wr_ready_i=1 -> START for 1 cycle; rows 0..7 written with wr_init_o=1; pred_en_o=1 from cycle 10 after release.
- RUN, 4 updates on consecutive cycles (pcs 0x100, 0x104, 0x108, 0x10C), wr_ready_i=0 then 1 -> FIFO full; a 5th update raises drop_o; the four entries are issued in order, one per cycle, with matching taken bits.
- Full FIFO plus simultaneous pop and push -> push accepted, no drop_o, order preserved.
- flush_bp_i with 3 entries queued -> entries lost; sweep rows 0..NR_ROWS-1; pred_en_o=0 throughout; an update during the sweep gives drop_o=1.
- flush_bp_i at sweep row 5 -> next wr_row_o=0; full NR_ROWS cycles to RUN.
- debug_mode_i=1 with 2 queued entries plus a new update -> both queued entries drain; the new one is neither written nor dropped (drop_o=0).
